// File: rtl/alu_arb_pkg.sv
// Shared opcode encoding and FSM state type for the arbitrated ALU.
package alu_arb_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHR = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin select: first valid requester searching upward from ptr+1 with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [ID_W-1:0]    idx_o
);

  always_comb begin
    logic [ID_W-1:0] cand;
    logic            found;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = ptr_i;
    for (int i = 0; i < NUM_REQ; i++) begin
      // explicit wrap keeps non-power-of-two NUM_REQ inside the valid range
      cand = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
      if (!found && valid_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin shared 8-bit ALU: accept in cycle T, tagged result valid in T+2, held until rsp_ready_i.
// New requests are refused until the response handshakes; ALU_FLAGS_EN adds registered zero/carry outputs.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_valid_i,
  input  logic [NUM_REQ*8-1:0] req_a_i,
  input  logic [NUM_REQ*8-1:0] req_b_i,
  input  logic [NUM_REQ*3-1:0] req_op_i,
  output logic [NUM_REQ-1:0]   req_ready_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [7:0]           rsp_data_o
`ifdef ALU_FLAGS_EN
  ,
  output logic                 rsp_zero_o,
  output logic                 rsp_carry_o
`endif
);

  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [7:0]      a_q, a_d, b_q, b_d;
  logic [2:0]      op_q, op_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [7:0]      rsp_data_q, rsp_data_d;
  logic [7:0]      alu_res;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [ID_W-1:0]    arb_idx;
  logic [7:0]         a_arr  [NUM_REQ];
  logic [7:0]         b_arr  [NUM_REQ];
  logic [2:0]         op_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign a_arr[k]  = req_a_i[8*k +: 8];
    assign b_arr[k]  = req_b_i[8*k +: 8];
    assign op_arr[k] = req_op_i[3*k +: 3];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (ptr_q),
    .grant_o (arb_gnt),
    .idx_o   (arb_idx)
  );

`ifdef ALU_FLAGS_EN
  logic       zero_q, zero_d, carry_q, carry_d;
  logic       alu_carry;
  logic [8:0] sum9;
  assign sum9 = {1'b0, a_q} + {1'b0, b_q};
`endif

  // Shift amount is the full 8-bit b, so b >= 8 naturally yields zero.
  always_comb begin
    alu_res = '0;
`ifdef ALU_FLAGS_EN
    alu_carry = 1'b0;
`endif
    case (op_q)
      OP_ADD: begin
`ifdef ALU_FLAGS_EN
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
`else
        alu_res   = a_q + b_q;
`endif
      end
      OP_SUB: begin
        alu_res = a_q - b_q;
`ifdef ALU_FLAGS_EN
        alu_carry = (a_q < b_q);
`endif
      end
      OP_AND:          alu_res = a_q & b_q;
      OP_OR:           alu_res = a_q | b_q;
      OP_XOR:          alu_res = a_q ^ b_q;
      OP_SHR:          alu_res = a_q >> b_q;
      OP_SHL, 3'b111:  alu_res = a_q << b_q;
      default:         alu_res = '0;
    endcase
  end

  // Grant depends only on state and request valids, never on rsp_ready_i.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    req_ready_o = '0;
`ifdef ALU_FLAGS_EN
    zero_d  = zero_q;
    carry_d = carry_q;
`endif
    case (state_q)
      IDLE: begin
        req_ready_o = arb_gnt;
        if (|req_valid_i) begin
          a_d      = a_arr[arb_idx];
          b_d      = b_arr[arb_idx];
          op_d     = op_arr[arb_idx];
          rsp_id_d = arb_idx;
          ptr_d    = arb_idx;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_res;
        rsp_valid_d = 1'b1;
`ifdef ALU_FLAGS_EN
        zero_d  = (alu_res == 8'h00);
        carry_d = alu_carry;
`endif
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= ID_W'(NUM_REQ - 1);
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
`ifdef ALU_FLAGS_EN
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
`ifdef ALU_FLAGS_EN
      zero_q      <= zero_d;
      carry_q     <= carry_d;
`endif
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_id_o    = rsp_id_q;
  assign rsp_data_o  = rsp_data_q;
`ifdef ALU_FLAGS_EN
  assign rsp_zero_o  = zero_q;
  assign rsp_carry_o = carry_q;
`endif

endmodule
